// File: rtl/jpeg_block_sequencer.sv
// jpeg_block_sequencer
//   Per-8x8-block controller for the HW_JPEGenc datapath. One start/busy
//   handshake runs one block through: input buffer load -> DCT_2D -> DCT
//   result capture -> row-wise Quantize/zigzag fill -> zigzag scan ->
//   Huffman encode.
//
// Optional build macro: JPEG_SEQ_PERF_EN adds the blk_count/last_cycles
// performance counters. When it is undefined those ports do not exist.
//
// Parameters
//   DCT_LATENCY    cycles from dct_enable until DCT_2D output valid (>=1)
//   QUANT_LATENCY  Quantize clk-to-out latency in cycles (>=0)
//   HUFF_TIMEOUT   max cycles waiting for huff_done before abort (>=2)
//
// Ports
//   clock, reset_n       system clock, async active-low reset
//   start                request one block (accepted only while idle)
//   load_mode            sampled with start: 0 parallel load, 1 serial load
//   luma_in              sampled with start: 1 luminance, 0 chrominance
//   pix_valid            serial-load beat qualifier
//   huff_done            Huffman controller finished the block
//   abort                synchronous return to IDLE
//   busy                 high from accepted start through the block_done cycle
//   input_enable         parallel buffer load strobe
//   input_1pix_enable    serial buffer load strobe (pix_valid while serial LOAD)
//   dct_enable           DCT start pulse
//   dct_end_enable       DCT result capture pulse
//   matrix_row[7:0]      current Quantize/zigzag row 0..7
//   zigzag_input_enable  write current quantized row into zigzag buffer
//   zigag_enable         zigzag scan pulse
//   Huffman_start        Huffman encode start pulse
//   is_luminance         luma_in latched for the whole block
//   block_done           one-cycle end-of-block pulse
//   timeout_err          sticky Huffman timeout flag, cleared by next start
//   blk_count[15:0]      (perf) completed blocks, wrapping
//   last_cycles[15:0]    (perf) busy cycles of last completed block, saturating
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | waiting for start
// S_LOAD     | input buffer load (1 cycle parallel, 64 beats serial)
// S_DCT_GO   | dct_enable pulse
// S_DCT_WAIT | waiting DCT_LATENCY cycles for DCT_2D output
// S_DCT_CAP  | dct_end_enable pulse
// S_QUANT    | rows 0..7, QUANT_LATENCY+1 cycles each
// S_ZZ       | zigag_enable pulse
// S_HUFF_GO  | Huffman_start pulse, timeout timer loaded
// S_HUFF_WAIT| waiting for huff_done or timeout
// S_DONE     | block_done pulse
module jpeg_block_sequencer #(
  parameter int DCT_LATENCY   = 4,
  parameter int QUANT_LATENCY = 1,
  parameter int HUFF_TIMEOUT  = 1024
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        load_mode,
  input  logic        luma_in,
  input  logic        pix_valid,
  input  logic        huff_done,
  input  logic        abort,
  output logic        busy,
  output logic        input_enable,
  output logic        input_1pix_enable,
  output logic        dct_enable,
  output logic        dct_end_enable,
  output logic [7:0]  matrix_row,
  output logic        zigzag_input_enable,
  output logic        zigag_enable,
  output logic        Huffman_start,
  output logic        is_luminance,
  output logic        block_done,
  output logic        timeout_err
`ifdef JPEG_SEQ_PERF_EN
  ,
  output logic [15:0] blk_count,
  output logic [15:0] last_cycles
`endif
);

  // One shared down-counter serves all timed states, so size it for the largest load.
  localparam int T_A    = (DCT_LATENCY > HUFF_TIMEOUT) ? DCT_LATENCY : HUFF_TIMEOUT;
  localparam int T_MAX  = (T_A > QUANT_LATENCY + 1) ? T_A : QUANT_LATENCY + 1;
  localparam int TMR_W  = $clog2(T_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_DCT_GO,
    S_DCT_WAIT,
    S_DCT_CAP,
    S_QUANT,
    S_ZZ,
    S_HUFF_GO,
    S_HUFF_WAIT,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic [2:0]       row, row_nxt;
  logic [5:0]       pix_cnt, pix_nxt;
  logic             serial_q;
  logic             accept;
  logic             err_set;

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    row_nxt   = row;
    pix_nxt   = pix_cnt;
    accept    = 1'b0;
    err_set   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          pix_nxt   = '0;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!serial_q) begin
          state_nxt = S_DCT_GO;
        end else if (pix_valid) begin
          pix_nxt = pix_cnt + 6'd1;
          if (pix_cnt == 6'd63) state_nxt = S_DCT_GO;
        end
      end
      S_DCT_GO: begin
        state_nxt = S_DCT_WAIT;
        tmr_nxt   = TMR_W'(DCT_LATENCY - 1);
      end
      S_DCT_WAIT: begin
        if (tmr == '0) state_nxt = S_DCT_CAP;
        else           tmr_nxt   = tmr - TMR_W'(1);
      end
      S_DCT_CAP: begin
        state_nxt = S_QUANT;
        row_nxt   = '0;
        tmr_nxt   = TMR_W'(QUANT_LATENCY);
      end
      S_QUANT: begin
        if (tmr == '0) begin
          if (row == 3'd7) begin
            state_nxt = S_ZZ;
            row_nxt   = '0;
          end else begin
            row_nxt = row + 3'd1;
            tmr_nxt = TMR_W'(QUANT_LATENCY);
          end
        end else begin
          tmr_nxt = tmr - TMR_W'(1);
        end
      end
      S_ZZ: begin
        state_nxt = S_HUFF_GO;
      end
      S_HUFF_GO: begin
        state_nxt = S_HUFF_WAIT;
        tmr_nxt   = TMR_W'(HUFF_TIMEOUT - 1);
      end
      S_HUFF_WAIT: begin
        // huff_done on the terminal-count cycle still counts as a clean finish.
        if (huff_done) begin
          state_nxt = S_DONE;
        end else if (tmr == '0) begin
          state_nxt = S_DONE;
          err_set   = 1'b1;
        end else begin
          tmr_nxt = tmr - TMR_W'(1);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    // abort wins over everything, including a start seen in IDLE.
    if (abort) begin
      state_nxt = S_IDLE;
      tmr_nxt   = '0;
      row_nxt   = '0;
      accept    = 1'b0;
      err_set   = 1'b0;
    end
  end

  // Strobes are registered decodes of the next state so they line up with the state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state               <= S_IDLE;
      tmr                 <= '0;
      row                 <= '0;
      pix_cnt             <= '0;
      serial_q            <= 1'b0;
      is_luminance        <= 1'b0;
      timeout_err         <= 1'b0;
      busy                <= 1'b0;
      input_enable        <= 1'b0;
      dct_enable          <= 1'b0;
      dct_end_enable      <= 1'b0;
      zigzag_input_enable <= 1'b0;
      zigag_enable        <= 1'b0;
      Huffman_start       <= 1'b0;
      block_done          <= 1'b0;
    end else begin
      state               <= state_nxt;
      tmr                 <= tmr_nxt;
      row                 <= row_nxt;
      pix_cnt             <= pix_nxt;
      busy                <= (state_nxt != S_IDLE);
      input_enable        <= accept && !load_mode;
      dct_enable          <= (state_nxt == S_DCT_GO);
      dct_end_enable      <= (state_nxt == S_DCT_CAP);
      zigzag_input_enable <= (state_nxt == S_QUANT) && (tmr_nxt == '0);
      zigag_enable        <= (state_nxt == S_ZZ);
      Huffman_start       <= (state_nxt == S_HUFF_GO);
      block_done          <= (state_nxt == S_DONE);
      if (accept) begin
        serial_q     <= load_mode;
        is_luminance <= luma_in;
        timeout_err  <= 1'b0;
      end else if (err_set) begin
        timeout_err <= 1'b1;
      end
    end
  end

  // Serial strobe follows pix_valid in the same cycle so the buffer sees each beat as it arrives.
  assign input_1pix_enable = (state == S_LOAD) && serial_q && pix_valid;
  assign matrix_row        = {5'b00000, row};

`ifdef JPEG_SEQ_PERF_EN
  logic [15:0] cyc_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cyc_cnt     <= '0;
      blk_count   <= '0;
      last_cycles <= '0;
    end else begin
      if (accept) begin
        cyc_cnt <= 16'd1;
      end else if ((state_nxt != S_IDLE) && (cyc_cnt != 16'hFFFF)) begin
        cyc_cnt <= cyc_cnt + 16'd1;
      end
      if (state == S_DONE) begin
        blk_count   <= blk_count + 16'd1;
        last_cycles <= cyc_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_jpeg_block_sequencer.sv
// Testbench for jpeg_block_sequencer: expected strobe events are queued as
// each block is launched and matched against DUT strobes as they appear.
module tb_jpeg_block_sequencer;

  localparam int DL = 4;
  localparam int QL = 1;
  localparam int HT = 16;

  localparam int K_PIX  = 0;
  localparam int K_IN   = 1;
  localparam int K_DCT  = 2;
  localparam int K_CAP  = 3;
  localparam int K_ZZIN = 4;
  localparam int K_ZZ   = 5;
  localparam int K_HS   = 6;
  localparam int K_DONE = 7;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       load_mode = 1'b0;
  logic       luma_in = 1'b0;
  logic       pix_valid = 1'b0;
  logic       huff_done = 1'b0;
  logic       abort = 1'b0;
  logic       busy, input_enable, input_1pix_enable, dct_enable, dct_end_enable;
  logic [7:0] matrix_row;
  logic       zigzag_input_enable, zigag_enable, Huffman_start;
  logic       is_luminance, block_done, timeout_err;
`ifdef JPEG_SEQ_PERF_EN
  logic [15:0] blk_count, last_cycles;
`endif

  jpeg_block_sequencer #(
    .DCT_LATENCY  (DL),
    .QUANT_LATENCY(QL),
    .HUFF_TIMEOUT (HT)
  ) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .start              (start),
    .load_mode          (load_mode),
    .luma_in            (luma_in),
    .pix_valid          (pix_valid),
    .huff_done          (huff_done),
    .abort              (abort),
    .busy               (busy),
    .input_enable       (input_enable),
    .input_1pix_enable  (input_1pix_enable),
    .dct_enable         (dct_enable),
    .dct_end_enable     (dct_end_enable),
    .matrix_row         (matrix_row),
    .zigzag_input_enable(zigzag_input_enable),
    .zigag_enable       (zigag_enable),
    .Huffman_start      (Huffman_start),
    .is_luminance       (is_luminance),
    .block_done         (block_done),
    .timeout_err        (timeout_err)
`ifdef JPEG_SEQ_PERF_EN
    ,
    .blk_count          (blk_count),
    .last_cycles        (last_cycles)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_luma = 1'b0;

  typedef struct {
    int kind;
    int cyc;
    int row;
  } ev_t;
  ev_t sb[$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_ev(input int kind, input int c, input int row, input int cut);
    ev_t e;
    if (c < cut) begin
      e.kind = kind;
      e.cyc  = c;
      e.row  = row;
      sb.push_back(e);
    end
  endtask

  // b = cycle in which the accepted start is driven; w = huff_done delay after Huffman_start (0 = never)
  task automatic push_block(input int b, input bit serial, input int w, input int cut);
    int l, hs, dn;
    if (serial) begin
      for (int k = 0; k < 64; k++) push_ev(K_PIX, b + 1 + 2 * k, 0, cut);
      l = b + 127;
    end else begin
      push_ev(K_IN, b + 1, 0, cut);
      l = b + 1;
    end
    push_ev(K_DCT, l + 1, 0, cut);
    push_ev(K_CAP, l + 2 + DL, 0, cut);
    for (int r = 0; r < 8; r++) push_ev(K_ZZIN, l + 3 + DL + r * (QL + 1) + QL, r, cut);
    push_ev(K_ZZ, l + 3 + DL + 8 * (QL + 1), 0, cut);
    hs = l + 4 + DL + 8 * (QL + 1);
    push_ev(K_HS, hs, 0, cut);
    dn = (w > 0) ? hs + w + 1 : hs + 1 + HT;
    push_ev(K_DONE, dn, 0, cut);
  endtask

  task automatic sb_pop(input int kind, input int row);
    ev_t e;
    if (sb.size() == 0) begin
      check("sb_unexpected_strobe", kind, -1);
    end else begin
      e = sb.pop_front();
      check("sb_kind", kind, e.kind);
      check("sb_cycle", cyc, e.cyc);
      if (kind == K_ZZIN) check("sb_row", row, e.row);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (input_1pix_enable)   sb_pop(K_PIX, 0);
      if (input_enable)        sb_pop(K_IN, 0);
      if (dct_enable)          sb_pop(K_DCT, 0);
      if (dct_end_enable)      sb_pop(K_CAP, 0);
      if (zigzag_input_enable) sb_pop(K_ZZIN, int'(matrix_row));
      if (zigag_enable)        sb_pop(K_ZZ, 0);
      if (Huffman_start)       sb_pop(K_HS, 0);
      if (block_done)          sb_pop(K_DONE, 0);
      if (busy) begin
        check("is_luminance", is_luminance, exp_luma);
        check("row_range", int'(matrix_row > 8'd7), 0);
      end
    end
  end

  task automatic run_block(input bit serial, input bit luma, input int w, input int abort_at,
                           input int n);
    int b, l_off, hs_off, dn_off;
    bit noise;
    l_off  = serial ? 127 : 1;
    hs_off = l_off + 4 + DL + 8 * (QL + 1);
    dn_off = (w > 0) ? hs_off + w + 1 : hs_off + 1 + HT;
    tick();
    b         = cyc;
    start     = 1'b1;
    load_mode = serial;
    luma_in   = luma;
    exp_luma  = luma;
    pix_valid = 1'b1;
    huff_done = 1'b0;
    abort     = 1'b0;
    push_block(b, serial, w, (abort_at > 0) ? b + abort_at + 1 : b + 100000);
    for (int i = 1; i <= n; i++) begin
      tick();
      noise     = (abort_at < 0) ? (i < hs_off) : (i <= abort_at);
      start     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      luma_in   = 1'($urandom_range(0, 1));
      load_mode = 1'($urandom_range(0, 1));
      pix_valid = (serial && i <= 127) ? 1'(i % 2 == 1) : 1'($urandom_range(0, 1));
      huff_done = (w > 0 && i == hs_off + w) || (i == 10);
      abort     = (i == abort_at) || (abort_at > 0 && i == abort_at + 2);
      if (abort_at > 0 && (i == abort_at || i == abort_at + 2)) start = 1'b1;
      if (i == 1) check("err_cleared_on_start", timeout_err, 0);
      if (abort_at < 0) begin
        if (i == dn_off) begin
          check("timeout_err_at_done", timeout_err, int'(w == 0));
          check("busy_at_done", busy, 1);
        end
        if (i == dn_off + 1) check("busy_after_done", busy, 0);
      end else begin
        if (i == abort_at) check("row_before_abort", matrix_row, 3);
        if (i == abort_at + 1) begin
          check("abort_busy", busy, 0);
          check("abort_row", matrix_row, 0);
        end
        if (i == abort_at + 3) check("abort_over_start", busy, 0);
      end
    end
    start     = 1'b0;
    pix_valid = 1'b0;
    huff_done = 1'b0;
    abort     = 1'b0;
    check("sb_drain", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    int b;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_input_enable", input_enable, 0);
    check("rst_input_1pix_enable", input_1pix_enable, 0);
    check("rst_dct_enable", dct_enable, 0);
    check("rst_dct_end_enable", dct_end_enable, 0);
    check("rst_matrix_row", matrix_row, 0);
    check("rst_zigzag_input_enable", zigzag_input_enable, 0);
    check("rst_zigag_enable", zigag_enable, 0);
    check("rst_huffman_start", Huffman_start, 0);
    check("rst_is_luminance", is_luminance, 0);
    check("rst_block_done", block_done, 0);
    check("rst_timeout_err", timeout_err, 0);
    reset_n = 1'b1;
    repeat (2) tick();

    // parallel, luminance, huff_done 5 cycles after Huffman_start
    run_block(1'b0, 1'b1, 5, -1, 40);
`ifdef JPEG_SEQ_PERF_EN
    check("perf_blk_count", blk_count, 1);
    check("perf_last_cycles", last_cycles, 31);
`endif

    // serial load with pix_valid on alternate cycles, chrominance
    run_block(1'b1, 1'b0, 1, -1, 160);

    // start held high across two blocks
    tick();
    b         = cyc;
    start     = 1'b1;
    load_mode = 1'b0;
    luma_in   = 1'b1;
    exp_luma  = 1'b1;
    push_block(b, 1'b0, 1, b + 100000);
    push_block(b + 28, 1'b0, 1, b + 100000);
    for (int i = 1; i <= 60; i++) begin
      tick();
      start     = (i <= 48);
      huff_done = (i == 26) || (i == 54);
      if (i == 27) check("b2b_busy_done", busy, 1);
      if (i == 28) check("b2b_busy_gap", busy, 0);
      if (i == 29) check("b2b_busy_second", busy, 1);
      if (i == 56) check("b2b_busy_end", busy, 0);
    end
    start     = 1'b0;
    huff_done = 1'b0;
    check("sb_drain", sb.size(), 0);
    sb.delete();

    // Huffman timeout, then huff_done exactly on the timeout cycle
    run_block(1'b0, 1'b1, 0, -1, 48);
    check("timeout_err_sticky", timeout_err, 1);
    run_block(1'b0, 1'b0, HT, -1, 48);

    // abort in QUANT row 3, then abort beating start in IDLE
    run_block(1'b0, 1'b1, 5, 14, 40);

    // reset mid-block in DCT_WAIT
    tick();
    b         = cyc;
    start     = 1'b1;
    load_mode = 1'b0;
    luma_in   = 1'b1;
    exp_luma  = 1'b1;
    push_block(b, 1'b0, 3, b + 3);
    for (int i = 1; i <= 4; i++) begin
      tick();
      start = 1'b0;
    end
    check("pre_reset_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("reset_busy", busy, 0);
    check("reset_is_luminance", is_luminance, 0);
    check("reset_matrix_row", matrix_row, 0);
    check("reset_strobes", int'({input_enable, dct_enable, dct_end_enable, zigzag_input_enable,
                                 zigag_enable, Huffman_start, block_done, timeout_err}), 0);
`ifdef JPEG_SEQ_PERF_EN
    check("reset_blk_count", blk_count, 0);
`endif
    check("sb_drain", sb.size(), 0);
    sb.delete();
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    run_block(1'b0, 1'b1, 3, -1, 35);
`ifdef JPEG_SEQ_PERF_EN
    check("perf_blk_count_after_reset", blk_count, 1);
    check("perf_last_cycles_after_reset", last_cycles, 29);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
